// File: rtl/fpa_add_sequencer.sv
// fpa_add_sequencer
//
// Computes one W = N*K bit addition c = a + b + ci by running a single N-bit
// adder K times, least-significant chunk first, with the carry kept in a
// register between chunks. Operands come in on a valid/ready handshake and
// the result leaves on a second valid/ready handshake.
//
// Optional feature macro: FPA_ADD_SEQ_SUB_EN
//   When defined, the extra input 'sub' is latched with the operands. sub=1
//   computes a - b as a + ~b + 1 (ci ignored); co=1 then means "no borrow".
//
// Parameters:
//   N  chunk width (width of the shared adder), N >= 1
//   K  number of chunks per operation, K >= 1
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; discards any operation in flight
//   in_valid   operand request
//   in_ready   high in IDLE only
//   a, b, ci   operands and carry-in, sampled on accept
//   sub        subtract request (only with FPA_ADD_SEQ_SUB_EN)
//   out_valid  high in DONE; result held until out_ready
//   out_ready  result sink ready
//   c          W-bit sum
//   co         carry out of the most significant chunk
//   busy       high in RUN or DONE
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from in_valid/out_ready to any output.

module fpa_add_sequencer #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           ci,
`ifdef FPA_ADD_SEQ_SUB_EN
    input  logic           sub,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] c,
    output logic           co,
    output logic           busy
);

    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  result;
    logic [W-1:0]  result_next;

    logic [W-1:0]  b_load;
    logic          carry_load;

    logic [N-1:0]  a_chunk;
    logic [N-1:0]  b_chunk;
    logic [N-1:0]  sum_chunk;
    logic          cout;

    // Operand conditioning at accept time. Subtraction is folded into the
    // same adder by storing ~b and seeding the carry chain with 1.
`ifdef FPA_ADD_SEQ_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : ci;
`else
    assign b_load     = b;
    assign carry_load = ci;
`endif

    // Select the current chunk of each operand.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned j = 0; j < K; j++) begin
            if (idx == IW'(j)) begin
                a_chunk = a_reg[j*N +: N];
                b_chunk = b_reg[j*N +: N];
            end
        end
    end

    // The shared N-bit datapath: all terms zero-extended to N+1 bits.
    assign {cout, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{N{1'b0}}, carry};

    // Merge the fresh chunk into the result at the current index.
    always_comb begin
        result_next = result;
        for (int unsigned j = 0; j < K; j++) begin
            if (idx == IW'(j)) begin
                result_next[j*N +: N] = sum_chunk;
            end
        end
    end

    // Operand registers only change on accept, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_valid && !rst) begin
            a_reg <= a;
            b_reg <= b_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        carry  <= carry_load;
                        idx    <= '0;
                        result <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    result <= result_next;
                    carry  <= cout;
                    // idx parks on the last chunk; carry then holds co.
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign c         = result;
    assign co        = carry;

endmodule

// File: tb/tb_fpa_add_sequencer.sv
// Testbench for fpa_add_sequencer: two instances (N=8,K=4 and N=32,K=1,
// both W=32) checked every cycle against a transaction-level model that
// knows only the handshake timing and the W-bit sum.
module tb_fpa_add_sequencer;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    logic         iv   [2];
    logic         ir   [2];
    logic         ov   [2];
    logic         ordy [2];
    logic         ci_s [2];
    logic         co_s [2];
    logic         bz   [2];
    logic [W-1:0] a_s  [2];
    logic [W-1:0] b_s  [2];
    logic [W-1:0] c_s  [2];
`ifdef FPA_ADD_SEQ_SUB_EN
    logic         sub_s [2];
`endif

    always #5 clk = ~clk;

    fpa_add_sequencer #(.N(8), .K(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[0]), .b(b_s[0]), .ci(ci_s[0]),
`ifdef FPA_ADD_SEQ_SUB_EN
        .sub(sub_s[0]),
`endif
        .out_valid(ov[0]), .out_ready(ordy[0]), .c(c_s[0]), .co(co_s[0]),
        .busy(bz[0])
    );

    fpa_add_sequencer #(.N(32), .K(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[1]), .b(b_s[1]), .ci(ci_s[1]),
`ifdef FPA_ADD_SEQ_SUB_EN
        .sub(sub_s[1]),
`endif
        .out_valid(ov[1]), .out_ready(ordy[1]), .c(c_s[1]), .co(co_s[1]),
        .busy(bz[1])
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model state per lane: idle flag, edges left until the result appears,
    // the expected {co, c}, and whether the result is known to be cleared.
    int           lk     [2] = '{4, 1};
    bit           m_idle [2] = '{1'b1, 1'b1};
    int           m_wait [2] = '{0, 0};
    bit           m_zero [2] = '{1'b1, 1'b1};
    logic [W:0]   m_sum  [2];

    task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic expire(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
    endtask

    // One clock: capture inputs, advance the model on the edge, then compare
    // every DUT output against the model just after the edge.
    task automatic tick();
        logic [W-1:0] ca [2];
        logic [W-1:0] cb [2];
        logic [W-1:0] nb;
        logic         cci [2];
        logic         civ [2];
        logic         cor [2];
        logic         csb [2];
        logic         crst;
        crst = rst;
        for (int l = 0; l < 2; l++) begin
            ca[l]  = a_s[l];
            cb[l]  = b_s[l];
            cci[l] = ci_s[l];
            civ[l] = iv[l];
            cor[l] = ordy[l];
`ifdef FPA_ADD_SEQ_SUB_EN
            csb[l] = sub_s[l];
`else
            csb[l] = 1'b0;
`endif
        end
        @(posedge clk);
        cyc++;
        for (int l = 0; l < 2; l++) begin
            if (crst) begin
                m_idle[l] = 1'b1;
                m_wait[l] = 0;
                m_zero[l] = 1'b1;
            end else if (m_idle[l]) begin
                if (civ[l]) begin
                    m_idle[l] = 1'b0;
                    m_wait[l] = lk[l];
                    m_zero[l] = 1'b0;
                    if (csb[l]) begin
                        nb = ~cb[l];
                        m_sum[l] = {1'b0, ca[l]} + {1'b0, nb} + 33'd1;
                    end else begin
                        m_sum[l] = {1'b0, ca[l]} + {1'b0, cb[l]} + {{W{1'b0}}, cci[l]};
                    end
                end
            end else if (m_wait[l] > 0) begin
                m_wait[l] = m_wait[l] - 1;
            end else if (cor[l]) begin
                m_idle[l] = 1'b1;
            end
        end
        #1;
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("in_ready%0d", l), ir[l], m_idle[l]);
            chk($sformatf("busy%0d", l), bz[l], !m_idle[l]);
            chk($sformatf("out_valid%0d", l), ov[l], (!m_idle[l] && m_wait[l] == 0));
            if (!m_idle[l] && m_wait[l] == 0) begin
                chk($sformatf("c%0d", l), c_s[l], m_sum[l][W-1:0]);
                chk($sformatf("co%0d", l), co_s[l], m_sum[l][W]);
            end
            if (m_idle[l] && m_zero[l]) begin
                chk($sformatf("c_cleared%0d", l), c_s[l], '0);
                chk($sformatf("co_cleared%0d", l), co_s[l], '0);
            end
        end
    endtask

    // One operation with 'hold' cycles of backpressure once out_valid is up.
    task automatic run_op(input int l, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic civ, input int hold,
                          output logic [W-1:0] cg, output logic cog, output int lat);
        bit ok;
        a_s[l]  = av;
        b_s[l]  = bv;
        ci_s[l] = civ;
        iv[l]   = 1'b1;
        ordy[l] = (hold == 0);
        ok = 1'b0;
        lat = 0;
        cg = '0;
        cog = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = ir[l];
            tick();
        end
        iv[l] = 1'b0;
        if (!ok) begin
            expire("accept");
            return;
        end
        ok = ov[l];
        for (int t = 0; t < 20 && !ok; t++) begin
            tick();
            lat++;
            ok = ov[l];
        end
        if (!ok) begin
            expire("out_valid");
            return;
        end
        cg  = c_s[l];
        cog = co_s[l];
        for (int h = 0; h < hold; h++) tick();
        ordy[l] = 1'b1;
        tick();
        chk("in_ready_after_handshake", ir[l], 1'b1);
    endtask

    // in_valid and out_ready tied high; accepts must be exactly K+2 apart.
    task automatic back_to_back(input int l, input int nops);
        bit acc;
        int n;
        int last;
        n = 0;
        last = -1;
        a_s[l]  = $urandom;
        b_s[l]  = $urandom;
        ci_s[l] = 1'($urandom_range(0, 1));
        iv[l]   = 1'b1;
        ordy[l] = 1'b1;
        for (int t = 0; t < nops * (lk[l] + 2) + 20 && n < nops; t++) begin
            acc = ir[l];
            tick();
            if (acc) begin
                if (last >= 0) chk($sformatf("accept_spacing%0d", l), W'(cyc - last), W'(lk[l] + 2));
                last = cyc;
                n++;
                a_s[l]  = $urandom;
                b_s[l]  = $urandom;
                ci_s[l] = 1'($urandom_range(0, 1));
`ifdef FPA_ADD_SEQ_SUB_EN
                sub_s[l] = 1'($urandom_range(0, 1));
`endif
            end
        end
        iv[l] = 1'b0;
`ifdef FPA_ADD_SEQ_SUB_EN
        sub_s[l] = 1'b0;
`endif
        if (n < nops) expire("back_to_back");
        acc = ir[l];
        for (int t = 0; t < 20 && !acc; t++) begin
            tick();
            acc = ir[l];
        end
        if (!acc) expire("drain");
    endtask

    initial begin
        logic [W-1:0] cg;
        logic         cog;
        int           lat;
        bit           ok;

        for (int l = 0; l < 2; l++) begin
            iv[l]   = 1'b0;
            ordy[l] = 1'b1;
            a_s[l]  = '0;
            b_s[l]  = '0;
            ci_s[l] = 1'b0;
`ifdef FPA_ADD_SEQ_SUB_EN
            sub_s[l] = 1'b0;
`endif
        end
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", ir[0], 1'b1);
        chk("rst_out_valid", ov[0], 1'b0);
        chk("rst_busy", bz[0], 1'b0);
        chk("rst_c", c_s[0], '0);
        chk("rst_co", co_s[0], 1'b0);
        rst = 1'b0;
        tick();

        // Basic carry chain across the first chunk boundary.
        run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0, cg, cog, lat);
        chk("basic_c", cg, 32'h0000_0100);
        chk("basic_co", cog, 1'b0);
        chk("basic_latency", W'(lat), W'(4));
        chk("model_pin_basic", m_sum[0], 33'h0_0000_0100);

        // Full ripple with in_valid held high throughout the operation.
        a_s[0] = 32'hFFFF_FFFF; b_s[0] = '0; ci_s[0] = 1'b1;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = ir[0];
            tick();
        end
        if (!ok) expire("ripple_accept");
        for (int j = 0; j < 4; j++) begin
            chk("ripple_in_ready_low", ir[0], 1'b0);
            tick();
        end
        chk("ripple_out_valid", ov[0], 1'b1);
        chk("ripple_c", c_s[0], 32'h0000_0000);
        chk("ripple_co", co_s[0], 1'b1);
        iv[0] = 1'b0;
        tick();
        chk("ripple_in_ready_back", ir[0], 1'b1);

        // Backpressure: result must sit unchanged for 10 cycles.
        run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 10, cg, cog, lat);
        chk("bp_c", cg, 32'h2345_6789);
        chk("bp_co", cog, 1'b0);
        chk("bp_c_after", c_s[0], 32'h2345_6789);

        // Reset sampled at the end of the second RUN cycle.
        a_s[0] = 32'hDEAD_BEEF; b_s[0] = 32'h0F0F_0F0F; ci_s[0] = 1'b1;
        iv[0] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = ir[0];
            tick();
        end
        iv[0] = 1'b0;
        if (!ok) expire("rstmid_accept");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_in_ready", ir[0], 1'b1);
        chk("rstmid_out_valid", ov[0], 1'b0);
        chk("rstmid_c", c_s[0], '0);
        chk("rstmid_co", co_s[0], 1'b0);
        run_op(0, 32'd3, 32'd4, 1'b0, 0, cg, cog, lat);
        chk("after_rst_c", cg, 32'd7);

        // Single-chunk instance.
        run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, cg, cog, lat);
        chk("k1_c", cg, 32'h0000_0000);
        chk("k1_co", cog, 1'b1);
        chk("k1_latency", W'(lat), W'(1));

`ifdef FPA_ADD_SEQ_SUB_EN
        sub_s[0] = 1'b1;
        run_op(0, 32'd5, 32'd7, 1'b1, 0, cg, cog, lat);
        chk("sub_5m7_c", cg, 32'hFFFF_FFFE);
        chk("sub_5m7_co", cog, 1'b0);
        run_op(0, 32'd7, 32'd5, 1'b0, 0, cg, cog, lat);
        chk("sub_7m5_c", cg, 32'h0000_0002);
        chk("sub_7m5_co", cog, 1'b1);
        sub_s[0] = 1'b0;
`endif

        back_to_back(0, 100);
        back_to_back(1, 100);

        // Random operations with random backpressure on both instances.
        for (int i = 0; i < 20; i++) begin
            for (int l = 0; l < 2; l++) begin
`ifdef FPA_ADD_SEQ_SUB_EN
                sub_s[l] = 1'($urandom_range(0, 1));
`endif
                run_op(l, $urandom, $urandom, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), cg, cog, lat);
                chk("rand_latency", W'(lat), W'(lk[l]));
`ifdef FPA_ADD_SEQ_SUB_EN
                sub_s[l] = 1'b0;
`endif
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpa_add_sequencer.md
# fpa_add_sequencer

- Multi-cycle controller that computes one wide fixed-point addition by reusing a single N-bit reduced full-add datapath K times, least-significant chunk first.
- Carry is chained between chunks through a carry register.
- Sits between a valid/ready operand source and a valid/ready result sink in the FixedPointArithmetic Add unit.
- Lets the team add N*K-bit words without instantiating an N*K-bit adder.

## Interface
Parameters:
- N, 8, chunk width in bits (width of the shared adder datapath); N >= 1.
- K, 4, number of chunks per operation; K >= 1. Total operand width W = N*K.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A, sampled on accept.
- b  input  W  operand B, sampled on accept.
- ci  input  1  carry in, sampled on accept.
- sub  input  1  subtract request; present only with FPA_ADD_SEQ_SUB_EN.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts the result.
- c  output  W  result sum.
- co  output  1  carry out of the most significant chunk.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Chunk index idx uses ceil(log2(K)) bits, minimum 1.
- IDLE: in_ready=1.
  - If in_valid at an edge: latch a and b into operand registers, carry<=ci, idx<=0, clear the result register, go to RUN.
- RUN: each cycle the datapath computes {cout, s} = a[idx*N +: N] + b[idx*N +: N] + carry, with all terms zero-extended to N+1 bits.
  - At the edge: result[idx*N +: N]<=s, carry<=cout, idx<=idx+1.
  - When idx==K-1, go to DONE instead of incrementing.
- DONE: out_valid=1. c and co are held stable.
  - On out_valid && out_ready at an edge, go to IDLE.
- Arithmetic is modulo 2^W; the carry-out of chunk K-1 is co.
- K=1: RUN lasts one cycle and result equals a+b+ci.
- in_ready=0 in RUN and DONE. Requests arriving then are not accepted and must be held by the source.
- rst at any edge, including mid-RUN or in DONE with the result unconsumed: state<=IDLE, idx<=0, carry<=0, result<=0. The in-flight operation is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, c=0, co=0.
- Outputs are registered or decoded from state only; there is no combinational path from in_valid or out_ready to any output.
- Accept at edge E0. Chunk j is written at edge E(j+1). out_valid rises after edge EK, so latency is K cycles from the accept edge.
- With out_ready held high, the handshake occurs at E(K+1), in_ready rises after E(K+1), and the next accept is possible at E(K+2). Peak throughput is one operation per K+2 cycles.
- out_valid remains high indefinitely until out_ready is sampled high. c and co must not change during this wait.

## Configuration
- FPA_ADD_SEQ_SUB_EN defined:
  - Port sub exists and is latched on accept.
  - When latched sub=1, the block computes a - b as a + ~b + 1. The b register loads ~b, carry loads 1, and ci is ignored.
  - co=1 means no borrow.
  - When sub=0, behaviour is identical to the undefined case.
- FPA_ADD_SEQ_SUB_EN undefined:
  - Port sub is absent.
  - The block performs a + b + ci only.

## Test plan
All scenarios use N=8 and K=4 unless stated.
- Basic carry chain: a=0x000000FF, b=0x00000001, ci=0, out_ready=1 -> out_valid 4 cycles after accept, c=0x00000100, co=0.
- Full ripple: a=0xFFFFFFFF, b=0x00000000, ci=1 -> c=0x00000000, co=1. in_ready stays 0 while busy, even with in_valid held high.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with a=0x12345678, b=0x11111111 -> c=0x23456789 held stable with out_valid=1, then handshake, then in_ready=1 the following cycle.
- Reset mid-operation: assert rst during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, c=0, co=0. A subsequent add of 3+4 gives c=7.
- Back-to-back with in_valid and out_ready tied high -> accepts spaced exactly K+2=6 cycles apart, and results match a+b+ci for 100 random vectors. Repeat with K=1, N=32.
- With FPA_ADD_SEQ_SUB_EN, sub=1: a=5, b=7 -> c=0xFFFFFFFE, co=0. a=7, b=5 -> c=0x00000002, co=1.
